// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the ALU issue stage: MIPS funct codes,
//               I-type opcodes and the issue-entry record.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_FUNC_W = 6;

    // ALU function codes, numerically equal to the MIPS R-type funct field
    typedef enum logic [5:0] {
        F_SLL  = 6'h00,
        F_SRL  = 6'h02,
        F_SRA  = 6'h03,
        F_ADD  = 6'h20,
        F_ADDU = 6'h21,
        F_SUB  = 6'h22,
        F_SUBU = 6'h23,
        F_AND  = 6'h24,
        F_OR   = 6'h25,
        F_XOR  = 6'h26,
        F_NOR  = 6'h27,
        F_SLT  = 6'h2A,
        F_SLTU = 6'h2B
    } alu_func_e;

    // Primary opcodes handled by the issue stage
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // One decoded operation waiting to be issued (default widths)
    typedef struct packed {
        logic [ALU_DATA_W-1:0] op_A;
        logic [ALU_DATA_W-1:0] op_B;
        logic [ALU_FUNC_W-1:0] func;
        logic [4:0]            dest;
        logic                  illegal;
    } issue_entry_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_fifo
// Description : Two-entry in-order buffer with valid/ready on both sides.
//               in_ready depends only on the stored count, so there is no
//               combinational path from out_ready to in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_fifo
    import alu_pkg::*;
#(
    parameter type T = issue_entry_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic [1:0] count_q;
    logic       head_q;
    T           mem_q [2];

    logic push;
    logic pop;
    logic tail;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // Slot behind the head; with one entry stored it is the other slot
    assign tail      = head_q ^ count_q[0];
    assign out_data  = mem_q[head_q];

    // Storage, head pointer and occupancy; reset flushes everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[tail] <= in_data;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Decodes MIPS ALU instructions into operand/function records
//               and issues them through a two-entry in-order buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FUNC_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] op_A,
    output logic [DATA_WIDTH-1:0] op_B,
    output logic [FUNC_WIDTH-1:0] func,
    output logic [4:0]            dest,
    output logic                  illegal
);

    // Same layout as alu_pkg::issue_entry_t, sized by this instance
    typedef struct packed {
        logic [DATA_WIDTH-1:0] op_A;
        logic [DATA_WIDTH-1:0] op_B;
        logic [FUNC_WIDTH-1:0] func;
        logic [4:0]            dest;
        logic                  illegal;
    } entry_t;

    logic [5:0]  opcode;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        unused_rs_idx;
    entry_t      dec;
    entry_t      head;

    assign opcode        = instr[31:26];
    assign rt_idx        = instr[20:16];
    assign rd_idx        = instr[15:11];
    assign shamt         = instr[10:6];
    assign funct         = instr[5:0];
    assign imm           = instr[15:0];
    // Register values arrive pre-read, so the rs index itself is not needed
    assign unused_rs_idx = ^instr[25:21];

    // Combinational decode; anything unrecognised becomes an illegal ADDU of zeros
    always_comb begin
        dec         = '0;
        dec.func    = FUNC_WIDTH'(F_ADDU);
        dec.illegal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLT, F_SLTU: begin
                        dec.op_A    = rs_data;
                        dec.op_B    = rt_data;
                        dec.func    = FUNC_WIDTH'(funct);
                        dec.dest    = rd_idx;
                        dec.illegal = 1'b0;
                    end
                    F_SLL, F_SRL, F_SRA: begin
                        dec.op_A    = rt_data;
                        dec.op_B    = DATA_WIDTH'(shamt);
                        dec.func    = FUNC_WIDTH'(funct);
                        dec.dest    = rd_idx;
                        dec.illegal = 1'b0;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                dec.op_A    = rs_data;
                dec.op_B    = DATA_WIDTH'($signed(imm));
                dec.dest    = rt_idx;
                dec.illegal = 1'b0;
                case (opcode)
                    OP_ADDI:  dec.func = FUNC_WIDTH'(F_ADD);
                    OP_ADDIU: dec.func = FUNC_WIDTH'(F_ADDU);
                    OP_SLTI:  dec.func = FUNC_WIDTH'(F_SLT);
                    default:  dec.func = FUNC_WIDTH'(F_SLTU);
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec.op_A    = rs_data;
                dec.op_B    = DATA_WIDTH'(imm);
                dec.dest    = rt_idx;
                dec.illegal = 1'b0;
                case (opcode)
                    OP_ANDI: dec.func = FUNC_WIDTH'(F_AND);
                    OP_ORI:  dec.func = FUNC_WIDTH'(F_OR);
                    default: dec.func = FUNC_WIDTH'(F_XOR);
                endcase
            end
            OP_LUI: begin
                dec.op_B    = DATA_WIDTH'({imm, 16'h0000});
                dec.func    = FUNC_WIDTH'(F_OR);
                dec.dest    = rt_idx;
                dec.illegal = 1'b0;
            end
            default: ;
        endcase
    end

    alu_issue_fifo #(
        .T (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign op_A    = head.op_A;
    assign op_B    = head.op_B;
    assign func    = head.func;
    assign dest    = head.dest;
    assign illegal = head.illegal;

endmodule
`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand width.
REQ-002 Parameter FUNC_WIDTH, default 6, ALU function-code width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  instruction/operand beat valid.
REQ-007 in_ready  output  1  block can accept a beat.
REQ-008 instr  input  32  MIPS instruction word.
REQ-009 rs_data  input  DATA_WIDTH  register-file value of rs.
REQ-010 rt_data  input  DATA_WIDTH  register-file value of rt.
REQ-011 out_valid  output  1  issued ALU operation valid.
REQ-012 out_ready  input  1  ALU stage accepts the operation.
REQ-013 op_A, op_B  output  DATA_WIDTH  ALU operands.
REQ-014 func  output  FUNC_WIDTH  ALU function code (MIPS funct encoding).
REQ-015 dest  output  5  destination register index.
REQ-016 illegal  output  1  instruction not supported by the ALU.

Function
REQ-017 Beat accepted when in_valid && in_ready at a rising edge; issued when out_valid && out_ready.
REQ-018 Decode SHALL be registered into a 2-entry in-order buffer; latency 1 cycle from acceptance into an empty buffer to out_valid=1.
REQ-019 in_ready SHALL equal (count != 2), registered-state only; no combinational path from out_ready to in_ready.
REQ-020 Simultaneous accept and issue SHALL leave count unchanged; head advances, new entry appended behind.
REQ-021 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-022 R-type (opcode 0x00): funct 0x20-0x27, 0x2A, 0x2B -> op_A=rs_data, op_B=rt_data, func=funct, dest=rd.
REQ-023 R-type shifts funct 0x00/0x02/0x03 -> op_A=rt_data, op_B=zero-extended shamt, func=funct, dest=rd.
REQ-024 I-type, dest=rt, op_A=rs_data: ADDI 0x08->0x20, ADDIU 0x09->0x21, SLTI 0x0A->0x2A, SLTIU 0x0B->0x2B with sign-extended imm; ANDI 0x0C->0x24, ORI 0x0D->0x25, XORI 0x0E->0x26 with zero-extended imm.
REQ-025 LUI 0x0F -> op_A=0, op_B={imm,16'h0000}, func=0x25, dest=rt.
REQ-026 Any other opcode/funct SHALL be issued with illegal=1, op_A=op_B=0, func=0x21, dest=0.
REQ-027 Writes to dest=0 SHALL be issued unchanged; suppression is downstream.

Reset
REQ-028 While rst_n=0: count=0, out_valid=0, op_A=op_B=0, func=0, dest=0, illegal=0; in_ready=1 from first edge after release.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries immediately, regardless of out_ready.

Structure
REQ-030 Package alu_pkg SHALL hold the funct enum (ADD...SLTU, SLL, SRL, SRA), I-type opcode constants, and the issue-entry struct (op_A, op_B, func, dest, illegal).
REQ-031 Decode SHALL be combinational in alu_issue; buffering SHALL be sub-module alu_issue_fifo (2 entries, parameterised on entry struct).

Verification
REQ-032 instr=0x2022FFFF, rs_data=5 -> next cycle op_A=0x00000005, op_B=0xFFFFFFFF, func=0x20, dest=2, illegal=0.
REQ-033 instr=0x34438000 -> op_B=0x00008000, func=0x25, dest=3; instr=0x3C011234 -> op_A=0, op_B=0x12340000, func=0x25, dest=1.
REQ-034 instr=0x00221822, rs_data=9, rt_data=4 -> op_A=9, op_B=4, func=0x22, dest=3; instr=0x00021083 -> op_A=rt_data, op_B=2, func=0x03, dest=2.
REQ-035 out_ready=0, three back-to-back beats -> in_ready=0 after second accept, third held; out_ready=1 -> three issued in order, no loss/duplication.
REQ-036 instr=0x8C220004 (LW) -> illegal=1, func=0x21, op_A=op_B=0, dest=0.
REQ-037 Two entries buffered, rst_n pulsed low mid-cycle -> out_valid=0 immediately, count=0, no buffered entry issued after release.
